// File: rtl/vector_bank_ctrl.sv
// vector_bank_ctrl: double-buffer controller for the vector-list RAM.
// Builder fills the back bank while the drawer reads the front bank.
// Ports: clk, rst_n (sync, active-low)
//   builder: build_go in, build_halt out, wr_adr/wr_data in
//   RAM: ram_wr_en/ram_wr_adr/ram_wr_data (registered), ram_rd_adr (comb)
//   drawer: draw_adr, draw_done in, draw_start out
//   status: wbank, frame_cnt, redraw_cnt, overflow, state_debug
module vector_bank_ctrl #(
   parameter int ADR_WIDTH  = 16,
   parameter int DATAWIDTH  = 18,
   parameter int BANK_DEPTH = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 build_go,
   output logic                 build_halt,
   input  logic [ADR_WIDTH-1:0] wr_adr,
   input  logic [DATAWIDTH-1:0] wr_data,
   output logic                 ram_wr_en,
   output logic [ADR_WIDTH:0]   ram_wr_adr,
   output logic [DATAWIDTH-1:0] ram_wr_data,
   input  logic [ADR_WIDTH-1:0] draw_adr,
   output logic [ADR_WIDTH:0]   ram_rd_adr,
   input  logic                 draw_done,
   output logic                 draw_start,
   output logic                 wbank,
   output logic [7:0]           frame_cnt,
   output logic [7:0]           redraw_cnt,
   output logic                 overflow,
   output logic [1:0]           state_debug
);

   typedef enum logic [1:0] {
      BUILD   = 2'd0,
      BUILT   = 2'd1,
      RELEASE = 2'd2,
      ARM     = 2'd3
   } bstate_t;

   typedef enum logic {
      IDLE = 1'b0,
      DRAW = 1'b1
   } dstate_t;

   localparam logic [ADR_WIDTH:0] LP_DEPTH = (ADR_WIDTH+1)'(BANK_DEPTH);

   bstate_t                r_bstate;
   dstate_t                r_dstate;
   logic                   r_pending;
   logic                   r_wr_en;
   logic [ADR_WIDTH:0]     r_wr_adr;
   logic [DATAWIDTH-1:0]   r_wr_data;
   logic                   r_halt;
   logic                   r_draw_start;
   logic                   r_wbank;
   logic [7:0]             r_frame_cnt;
   logic [7:0]             r_redraw_cnt;
   logic                   r_overflow;

   logic                   w_in_range;
   logic                   w_wr_open;
   logic                   w_latch;
   logic                   w_swap;
   logic                   w_redraw;

   assign w_in_range = ({1'b0, wr_adr} < LP_DEPTH);
   assign w_wr_open  = (r_bstate == BUILD) || (r_bstate == ARM);

   // go and done together while building: the list is taken first and the
   // end-of-list is held so the swap follows one cycle later.
   assign w_latch  = (r_bstate == BUILD) && build_go && draw_done
                     && (r_dstate == DRAW);
   assign w_swap   = (r_bstate == BUILT)
                     && ((r_dstate == IDLE) || draw_done || r_pending);
   assign w_redraw = draw_done && (r_dstate == DRAW) && !w_swap && !w_latch;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bstate     <= BUILD;
         r_dstate     <= IDLE;
         r_pending    <= 1'b0;
         r_wr_en      <= 1'b0;
         r_wr_adr     <= '0;
         r_wr_data    <= '0;
         r_halt       <= 1'b1;
         r_draw_start <= 1'b0;
         r_wbank      <= 1'b0;
         r_frame_cnt  <= 8'd0;
         r_redraw_cnt <= 8'd0;
         r_overflow   <= 1'b0;
      end else begin
         r_wr_en      <= w_wr_open && w_in_range;
         r_wr_adr     <= {r_wbank, wr_adr};
         r_wr_data    <= wr_data;
         r_draw_start <= w_swap || w_redraw;
         // halt drops only for the cycle spent in RELEASE
         r_halt       <= !w_swap;

         if (w_wr_open && !w_in_range)
            r_overflow <= 1'b1;

         if (w_redraw)
            r_redraw_cnt <= r_redraw_cnt + 8'd1;

         if (w_swap) begin
            r_wbank     <= ~r_wbank;
            r_frame_cnt <= r_frame_cnt + 8'd1;
            r_dstate    <= DRAW;
            r_pending   <= 1'b0;
         end else if (w_latch) begin
            r_pending   <= 1'b1;
         end

         unique case (r_bstate)
            BUILD:   if (build_go)  r_bstate <= BUILT;
            BUILT:   if (w_swap)    r_bstate <= RELEASE;
            RELEASE:                r_bstate <= ARM;
            ARM:     if (!build_go) r_bstate <= BUILD;
            default:                r_bstate <= BUILD;
         endcase
      end
   end

   assign build_halt  = r_halt;
   assign ram_wr_en   = r_wr_en;
   assign ram_wr_adr  = r_wr_adr;
   assign ram_wr_data = r_wr_data;
   assign ram_rd_adr  = {~r_wbank, draw_adr};
   assign draw_start  = r_draw_start;
   assign wbank       = r_wbank;
   assign frame_cnt   = r_frame_cnt;
   assign redraw_cnt  = r_redraw_cnt;
   assign overflow    = r_overflow;
   assign state_debug = r_bstate;

endmodule

// File: tb/tb_vector_bank_ctrl.sv
// tb_vector_bank_ctrl: directed table-driven bench for vector_bank_ctrl.
// Rows give inputs for one cycle and the outputs expected after the edge.
module tb_vector_bank_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        build_go;
   logic        build_halt;
   logic [15:0] wr_adr;
   logic [17:0] wr_data;
   logic        ram_wr_en;
   logic [16:0] ram_wr_adr;
   logic [17:0] ram_wr_data;
   logic [15:0] draw_adr;
   logic [16:0] ram_rd_adr;
   logic        draw_done;
   logic        draw_start;
   logic        wbank;
   logic [7:0]  frame_cnt;
   logic [7:0]  redraw_cnt;
   logic        overflow;
   logic [1:0]  state_debug;

   int n_chk  = 0;
   int n_fail = 0;

   vector_bank_ctrl #(
      .ADR_WIDTH(16), .DATAWIDTH(18), .BANK_DEPTH(1024)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .build_go(build_go), .build_halt(build_halt),
      .wr_adr(wr_adr), .wr_data(wr_data),
      .ram_wr_en(ram_wr_en), .ram_wr_adr(ram_wr_adr),
      .ram_wr_data(ram_wr_data),
      .draw_adr(draw_adr), .ram_rd_adr(ram_rd_adr),
      .draw_done(draw_done), .draw_start(draw_start),
      .wbank(wbank), .frame_cnt(frame_cnt), .redraw_cnt(redraw_cnt),
      .overflow(overflow), .state_debug(state_debug)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        go;
      logic        done;
      logic [15:0] adr;
      logic [17:0] dat;
      logic        wen;
      logic [16:0] wa;
      logic        wb;
      logic [7:0]  fc;
      logic [7:0]  rc;
      logic        ds;
      logic        h;
      logic [1:0]  st;
      logic        ov;
   } vec_t;

   vec_t tbl[32];

   function automatic vec_t mk(
      input logic go, input logic done,
      input logic [15:0] adr, input logic [17:0] dat,
      input logic wen, input logic [16:0] wa, input logic wb,
      input logic [7:0] fc, input logic [7:0] rc,
      input logic ds, input logic h, input logic [1:0] st,
      input logic ov);
      vec_t v;
      v.go = go;  v.done = done; v.adr = adr; v.dat = dat;
      v.wen = wen; v.wa = wa; v.wb = wb; v.fc = fc; v.rc = rc;
      v.ds = ds;  v.h = h; v.st = st; v.ov = ov;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " halt"},   32'(build_halt),  32'd1);
      chk({tag, " wr_en"},  32'(ram_wr_en),   32'd0);
      chk({tag, " wr_adr"}, 32'(ram_wr_adr),  32'd0);
      chk({tag, " wr_dat"}, 32'(ram_wr_data), 32'd0);
      chk({tag, " dstart"}, 32'(draw_start),  32'd0);
      chk({tag, " wbank"},  32'(wbank),       32'd0);
      chk({tag, " fcnt"},   32'(frame_cnt),   32'd0);
      chk({tag, " rcnt"},   32'(redraw_cnt),  32'd0);
      chk({tag, " ovf"},    32'(overflow),    32'd0);
      chk({tag, " state"},  32'(state_debug), 32'd0);
   endtask

   initial begin
      int n;
      logic [16:0] exp_rd;
      // go  dn adr     dat       wen wa        wb fc rc ds h st ov
      tbl[0]  = mk(0,0,16'd0,   18'h100, 1,17'h00000,0,0,0,0,1,0,0);
      tbl[1]  = mk(0,0,16'd1,   18'h101, 1,17'h00001,0,0,0,0,1,0,0);
      tbl[2]  = mk(0,0,16'd2,   18'h102, 1,17'h00002,0,0,0,0,1,0,0);
      tbl[3]  = mk(0,0,16'd3,   18'h103, 1,17'h00003,0,0,0,0,1,0,0);
      tbl[4]  = mk(0,0,16'd4,   18'h104, 1,17'h00004,0,0,0,0,1,0,0);
      tbl[5]  = mk(0,0,16'd5,   18'h105, 1,17'h00005,0,0,0,0,1,0,0);
      tbl[6]  = mk(1,0,16'd6,   18'h106, 1,17'h00006,0,0,0,0,1,1,0);
      tbl[7]  = mk(1,0,16'd0,   18'h0,   0,17'h00000,1,1,0,1,0,2,0);
      tbl[8]  = mk(1,0,16'd0,   18'h0,   0,17'h10000,1,1,0,0,1,3,0);
      tbl[9]  = mk(1,0,16'd0,   18'h0,   1,17'h10000,1,1,0,0,1,3,0);
      tbl[10] = mk(1,0,16'd0,   18'h0,   1,17'h10000,1,1,0,0,1,3,0);
      tbl[11] = mk(1,0,16'd0,   18'h0,   1,17'h10000,1,1,0,0,1,3,0);
      tbl[12] = mk(1,0,16'd0,   18'h0,   1,17'h10000,1,1,0,0,1,3,0);
      tbl[13] = mk(0,0,16'd0,   18'h0,   1,17'h10000,1,1,0,0,1,0,0);
      tbl[14] = mk(0,1,16'd0,   18'h0,   1,17'h10000,1,1,1,1,1,0,0);
      tbl[15] = mk(0,0,16'd0,   18'h0,   1,17'h10000,1,1,1,0,1,0,0);
      tbl[16] = mk(0,1,16'd0,   18'h0,   1,17'h10000,1,1,2,1,1,0,0);
      tbl[17] = mk(0,0,16'd0,   18'h0,   1,17'h10000,1,1,2,0,1,0,0);
      tbl[18] = mk(0,1,16'd0,   18'h0,   1,17'h10000,1,1,3,1,1,0,0);
      tbl[19] = mk(0,0,16'd0,   18'h0,   1,17'h10000,1,1,3,0,1,0,0);
      tbl[20] = mk(0,0,16'd1024,18'h0,   0,17'h10400,1,1,3,0,1,0,1);
      tbl[21] = mk(0,0,16'd7,   18'h2AA, 1,17'h10007,1,1,3,0,1,0,1);
      tbl[22] = mk(1,0,16'd8,   18'h3FFFF,1,17'h10008,1,1,3,0,1,1,1);
      tbl[23] = mk(1,0,16'd8,   18'h0,   0,17'h10008,1,1,3,0,1,1,1);
      tbl[24] = mk(1,0,16'd8,   18'h0,   0,17'h10008,1,1,3,0,1,1,1);
      tbl[25] = mk(1,1,16'd8,   18'h0,   0,17'h10008,0,2,3,1,0,2,1);
      tbl[26] = mk(1,0,16'd0,   18'h0,   0,17'h00000,0,2,3,0,1,3,1);
      tbl[27] = mk(0,0,16'd0,   18'h0,   1,17'h00000,0,2,3,0,1,0,1);
      tbl[28] = mk(1,1,16'd0,   18'h0,   1,17'h00000,0,2,3,0,1,1,1);
      tbl[29] = mk(1,0,16'd0,   18'h0,   0,17'h00000,1,3,3,1,0,2,1);
      tbl[30] = mk(1,0,16'd0,   18'h0,   0,17'h10000,1,3,3,0,1,3,1);
      tbl[31] = mk(0,0,16'd0,   18'h0,   1,17'h10000,1,3,3,0,1,0,1);

      rst_n     = 1'b0;
      build_go  = 1'b0;
      wr_adr    = '0;
      wr_data   = '0;
      draw_adr  = 16'h0ABC;
      draw_done = 1'b0;
      tick();
      tick();
      chk_reset("rst");
      chk("rst rd_adr", 32'(ram_rd_adr), 32'h10ABC);
      rst_n = 1'b1;

      for (int i = 0; i < 32; i++) begin
         build_go  = tbl[i].go;
         draw_done = tbl[i].done;
         wr_adr    = tbl[i].adr;
         wr_data   = tbl[i].dat;
         draw_adr  = 16'(i);
         tick();
         exp_rd = {~tbl[i].wb, 16'(i)};
         chk($sformatf("r%0d wr_en", i),  32'(ram_wr_en),   32'(tbl[i].wen));
         chk($sformatf("r%0d wr_adr", i), 32'(ram_wr_adr),  32'(tbl[i].wa));
         chk($sformatf("r%0d wr_dat", i), 32'(ram_wr_data), 32'(tbl[i].dat));
         chk($sformatf("r%0d wbank", i),  32'(wbank),       32'(tbl[i].wb));
         chk($sformatf("r%0d fcnt", i),   32'(frame_cnt),   32'(tbl[i].fc));
         chk($sformatf("r%0d rcnt", i),   32'(redraw_cnt),  32'(tbl[i].rc));
         chk($sformatf("r%0d dstart", i), 32'(draw_start),  32'(tbl[i].ds));
         chk($sformatf("r%0d halt", i),   32'(build_halt),  32'(tbl[i].h));
         chk($sformatf("r%0d state", i),  32'(state_debug), 32'(tbl[i].st));
         chk($sformatf("r%0d ovf", i),    32'(overflow),    32'(tbl[i].ov));
         chk($sformatf("r%0d rd_adr", i), 32'(ram_rd_adr),  32'(exp_rd));
      end

      // four more full frames to reach frame_cnt = 7 while drawing
      draw_done = 1'b0;
      for (int k = 0; k < 4; k++) begin
         build_go = 1'b1; tick();
         draw_done = 1'b1; tick();
         draw_done = 1'b0; tick();
         build_go = 1'b0; tick();
      end
      chk("pre-rst fcnt", 32'(frame_cnt), 32'd7);
      chk("pre-rst wbank", 32'(wbank), 32'd1);

      rst_n = 1'b0;
      tick();
      chk_reset("midrst");
      rst_n = 1'b1;

      // end marker with no valid front bank is ignored
      draw_done = 1'b1;
      tick();
      draw_done = 1'b0;
      chk("idle done dstart", 32'(draw_start), 32'd0);
      chk("idle done rcnt", 32'(redraw_cnt), 32'd0);
      n = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (draw_start) n++;
      end
      chk("no start pre-go", 32'(n), 32'd0);

      build_go = 1'b1;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         n++;
         if (draw_start) break;
      end
      chk("first start seen", 32'(draw_start), 32'd1);
      chk("first start lat", 32'(n), 32'd2);
      chk("first wbank", 32'(wbank), 32'd1);
      chk("first fcnt", 32'(frame_cnt), 32'd1);
      chk("first halt", 32'(build_halt), 32'd0);
      build_go = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
